// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the memory request arbiter.
package mem_arb_pkg;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   // Ceiling log2 with a floor of 1 so a 1-bit index always exists.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int k = 1; k < 31; k++) begin
         if ((1 << r) < n) r = r + 1;
      end
      return r;
   endfunction

   // Cache id = {requester index, local tag}; generic 16-bit form.
   function automatic logic [15:0] id_pack(input int idx, input int tag, input int tag_w);
      return 16'((idx << tag_w) | tag);
   endfunction

   function automatic int id_idx(input logic [15:0] id, input int tag_w);
      return int'(id >> tag_w);
   endfunction

   function automatic int id_tag(input logic [15:0] id, input int tag_w);
      return int'(id & 16'((1 << tag_w) - 1));
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Stateless round-robin pick: first eligible requester at or after the pointer.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
)(
   input  logic [N-1:0]     i_elig,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   // Scan N slots starting at the pointer, wrapping, and keep the first hit.
   always_comb begin : p_pick
      int j;
      j       = 0;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = int'(i_ptr) + k;
         if (j >= N) j = j - N;
         if (!o_any && i_elig[j]) begin
            o_grant[j] = 1'b1;
            o_idx      = IDX_W'(j);
            o_any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one cache port among NUM_REQ requesters: round-robin grant into a single
// registered request stage, per-requester outstanding-read limit, response steering.
// Cache handshake: a request moves to the cache on a clock edge where valid_out=1 and
// stall_in=0; while stalled the staged request holds unchanged. Responses are never
// back-pressured: rready_in=1 means rdata_in/rid_in are valid this cycle.
module mem_req_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 4,
   parameter int MAX_OUT = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   localparam int REQ_W  = clog2(NUM_REQ),
   localparam int CID_W  = REQ_W + TAG_W
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_rw,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
   output logic [NUM_REQ-1:0]        req_grant,
   output logic [ADDR_W-1:0]         addr_out,
   output logic [DATA_W-1:0]         data_out,
   output logic                      rw_out,
   output logic                      valid_out,
   output logic [CID_W-1:0]          id_out,
   input  logic                      stall_in,
   input  logic [DATA_W-1:0]         rdata_in,
   input  logic [CID_W-1:0]          rid_in,
   input  logic                      rready_in,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic [TAG_W-1:0]          rsp_tag,
   output logic                      err_out
);

   localparam int                CNT_W    = clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0]  MAX_C    = CNT_W'(MAX_OUT);
   localparam logic [REQ_W-1:0]  LAST_IDX = REQ_W'(NUM_REQ - 1);

   logic [REQ_W-1:0]   r_ptr;
   logic               r_valid;
   logic               r_rw;
   logic [ADDR_W-1:0]  r_addr;
   logic [DATA_W-1:0]  r_data;
   logic [CID_W-1:0]   r_id;
   logic [CNT_W-1:0]   r_cnt [NUM_REQ];
   logic [NUM_REQ-1:0] r_rsp_valid;
   logic [DATA_W-1:0]  r_rsp_data;
   logic [TAG_W-1:0]   r_rsp_tag;
   logic               r_err;

   logic               w_stage_free;
   logic [NUM_REQ-1:0] w_elig;
   logic [NUM_REQ-1:0] w_elig_q;
   logic [NUM_REQ-1:0] w_grant;
   logic [REQ_W-1:0]   w_gidx;
   logic               w_any;
   logic [ADDR_W-1:0]  w_sel_addr;
   logic [DATA_W-1:0]  w_sel_data;
   logic [TAG_W-1:0]   w_sel_tag;
   logic               w_sel_rw;
   logic [REQ_W-1:0]   w_rsp_idx;
   logic [TAG_W-1:0]   w_rsp_tag;
   logic               w_rsp_ok;
   logic [NUM_REQ-1:0] w_rsp_onehot;
   logic [NUM_REQ-1:0] w_inc;
   logic [NUM_REQ-1:0] w_dec;

   assign w_stage_free = !r_valid || !stall_in;

   // Eligibility: writes are posted, reads need headroom in their counter.
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_elig[i] = req_valid[i] && ((req_rw[i] == RW_WRITE) || (r_cnt[i] < MAX_C));
      end
   end

   assign w_elig_q = w_stage_free ? w_elig : '0;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (REQ_W)
   ) u_rr (
      .i_elig  (w_elig_q),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_gidx),
      .o_any   (w_any)
   );

   // The grant is forced low while reset is held so requesters never see a phantom capture.
   assign req_grant = reset ? w_grant : '0;

   // Mux out the granted requester's fields.
   always_comb begin
      w_sel_addr = '0;
      w_sel_data = '0;
      w_sel_tag  = '0;
      w_sel_rw   = RW_READ;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            w_sel_data = req_data[i*DATA_W +: DATA_W];
            w_sel_tag  = req_tag[i*TAG_W +: TAG_W];
            w_sel_rw   = req_rw[i];
         end
      end
   end

   // Response decode; an index beyond NUM_REQ is only possible for non power-of-2 counts.
   assign w_rsp_idx = rid_in[CID_W-1 -: REQ_W];
   assign w_rsp_tag = rid_in[TAG_W-1:0];
   assign w_rsp_ok  = {{(32-REQ_W){1'b0}}, w_rsp_idx} < 32'(NUM_REQ);

   // Per-requester counter up/down strobes.
   always_comb begin
      w_rsp_onehot = '0;
      w_inc        = '0;
      w_dec        = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_rsp_onehot[i] = (w_rsp_idx == REQ_W'(i));
         w_inc[i]        = w_grant[i] && (req_rw[i] == RW_READ);
         w_dec[i]        = rready_in && w_rsp_ok && w_rsp_onehot[i];
      end
   end

   // Round-robin pointer: advance past the winner, hold when nothing is granted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr <= '0;
      end else if (w_any) begin
         r_ptr <= (w_gidx == LAST_IDX) ? '0 : w_gidx + REQ_W'(1);
      end
   end

   // Request stage: load on grant, empty when free with no grant, hold while stalled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= 1'b0;
         r_rw    <= RW_READ;
         r_addr  <= '0;
         r_data  <= '0;
         r_id    <= '0;
      end else if (w_stage_free) begin
         if (w_any) begin
            r_valid <= 1'b1;
            r_rw    <= w_sel_rw;
            r_addr  <= w_sel_addr;
            r_data  <= w_sel_data;
            r_id    <= {w_gidx, w_sel_tag};
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   // Outstanding-read counters; simultaneous grant and response cancel out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_inc[i] && !w_dec[i] && (r_cnt[i] != MAX_C)) begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end else if (!w_inc[i] && w_dec[i] && (r_cnt[i] != '0)) begin
               r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end
         end
      end
   end

   // Response registers: one-cycle strobe to the owner, sticky error on a bad index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
         r_rsp_tag   <= '0;
         r_err       <= 1'b0;
      end else begin
         r_rsp_valid <= '0;
         if (rready_in) begin
            if (w_rsp_ok) begin
               r_rsp_valid <= w_rsp_onehot;
               r_rsp_data  <= rdata_in;
               r_rsp_tag   <= w_rsp_tag;
            end else begin
               r_err <= 1'b1;
            end
         end
      end
   end

   assign valid_out = r_valid;
   assign rw_out    = r_rw;
   assign addr_out  = r_addr;
   assign data_out  = r_data;
   assign id_out    = r_id;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_tag   = r_rsp_tag;
   assign err_out   = r_err;

endmodule
